// File: rtl/acs_pmu4_if.sv
// Interface bundle for the 4-state Viterbi add-compare-select unit.
// Carries the branch-metric input group, the frame-control strobe and the
// decision/path-metric output group. The branch-metric producer uses the
// master modport. The ACS unit uses the slave modport.
//   start       frame start pulse
//   bm_valid    branch metrics valid
//   bm00..bm11  2-bit Hamming metrics per expected symbol
//   dec_bits    survivor decisions, bit n = next state n
//   dec_valid   decision/metric update pulse
//   pm_flat     path metrics, state n at [n*W +: W]
//   best_state  index of minimum registered metric
//   frame_last  pulse with the final decision of a frame
//   busy        frame in progress
interface acs_pmu4_if #(
  parameter int unsigned W = 8
) ();
  logic             start;
  logic             bm_valid;
  logic [1:0]       bm00;
  logic [1:0]       bm01;
  logic [1:0]       bm10;
  logic [1:0]       bm11;
  logic [3:0]       dec_bits;
  logic             dec_valid;
  logic [4*W-1:0]   pm_flat;
  logic [1:0]       best_state;
  logic             frame_last;
  logic             busy;

  modport master (
    output start, bm_valid, bm00, bm01, bm10, bm11,
    input  dec_bits, dec_valid, pm_flat, best_state, frame_last, busy
  );

  modport slave (
    input  start, bm_valid, bm00, bm01, bm10, bm11,
    output dec_bits, dec_valid, pm_flat, best_state, frame_last, busy
  );
endinterface

// File: rtl/acs_pmu4.sv
// Add-compare-select / path-metric unit for a 4-state (K=3, 7/5 octal) Viterbi decoder.
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset
//   pmu_io  slave side of acs_pmu4_if (branch metrics in, decisions/metrics out)
// State index s = {b1, b2}, where b1 is the newest input bit. Each valid step produces four
// new metrics and four survivor bits, registered with one cycle of latency.
module acs_pmu4 #(
  parameter int unsigned W         = 8,
  parameter int unsigned INIT_PM   = 32,
  parameter int unsigned FRAME_LEN = 64
) (
  input logic         clk,
  input logic         rst_n,
  acs_pmu4_if.slave   pmu_io
);

  localparam int unsigned    CntW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(FRAME_LEN - 1);
  localparam logic [W-1:0]    InitPm  = W'(INIT_PM);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e               state_q, state_d;
  logic [3:0][W-1:0]    pm_q, pm_d, acs_pm, norm_pm;
  logic [3:0]           dec_q, dec_d, acs_dec;
  logic                 dv_q, dv_d, fl_q, fl_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0][1:0]      bm;
  logic                 all_msb;
  logic [1:0]           best;
  logic [W-1:0]         best_pm;

  // Indexed by the 2-bit expected symbol {c0, c1}.
  assign bm = {pmu_io.bm11, pmu_io.bm10, pmu_io.bm01, pmu_io.bm00};

  // Encoder output {c0, c1} leaving predecessor p = {b1, b2} on input u.
  function automatic logic [1:0] sym_f(input logic [1:0] p, input logic u);
    return {u ^ p[1] ^ p[0], u ^ p[0]};
  endfunction

  always_comb begin : acs
    logic [1:0] p0, p1;
    logic [W:0] c0, c1;
    p0      = '0;
    p1      = '0;
    c0      = '0;
    c1      = '0;
    acs_pm  = '0;
    acs_dec = '0;
    for (int n = 0; n < 4; n++) begin
      // Next state n = {u, b1}; predecessors are {b1, 0} and {b1, 1}.
      p0 = {n[0], 1'b0};
      p1 = {n[0], 1'b1};
      c0 = {1'b0, pm_q[p0]} + (W+1)'(bm[sym_f(p0, n[1])]);
      c1 = {1'b0, pm_q[p1]} + (W+1)'(bm[sym_f(p1, n[1])]);
      // Strict compare: ties go to the b2 = 0 predecessor.
      if (c1 < c0) begin
        acs_pm[n]  = c1[W-1:0];
        acs_dec[n] = 1'b1;
      end else begin
        acs_pm[n]  = c0[W-1:0];
      end
    end
  end

  // Metrics stay within a bounded spread, so dropping a common MSB preserves ordering.
  always_comb begin : normalise
    all_msb = acs_pm[0][W-1] & acs_pm[1][W-1] & acs_pm[2][W-1] & acs_pm[3][W-1];
    norm_pm = acs_pm;
    if (all_msb) begin
      for (int i = 0; i < 4; i++) begin
        norm_pm[i][W-1] = 1'b0;
      end
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    pm_d    = pm_q;
    cnt_d   = cnt_q;
    dec_d   = dec_q;
    dv_d    = 1'b0;
    fl_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pmu_io.start) begin
          state_d = StRun;
          pm_d    = {InitPm, InitPm, InitPm, {W{1'b0}}};
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (pmu_io.start) begin
          pm_d  = {InitPm, InitPm, InitPm, {W{1'b0}}};
          cnt_d = '0;
        end else if (pmu_io.bm_valid) begin
          pm_d  = norm_pm;
          dec_d = acs_dec;
          dv_d  = 1'b1;
          if (cnt_q == LastCnt) begin
            fl_d    = 1'b1;
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pm_q    <= '0;
      dec_q   <= '0;
      dv_q    <= 1'b0;
      fl_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pm_q    <= pm_d;
      dec_q   <= dec_d;
      dv_q    <= dv_d;
      fl_q    <= fl_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lowest index wins on equal metrics.
  always_comb begin : best_sel
    best    = 2'd0;
    best_pm = pm_q[0];
    for (int i = 1; i < 4; i++) begin
      if (pm_q[i] < best_pm) begin
        best_pm = pm_q[i];
        best    = 2'(i);
      end
    end
  end

  assign pmu_io.dec_bits   = dec_q;
  assign pmu_io.dec_valid  = dv_q;
  assign pmu_io.pm_flat    = pm_q;
  assign pmu_io.best_state = best;
  assign pmu_io.frame_last = fl_q;
  assign pmu_io.busy       = (state_q == StRun);

endmodule
